car_cmd_rx: RTL
===============

CAR_CMD_RX -- requirements
Module: car_cmd_rx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 10417, clk cycles per UART bit (100 MHz / 9600 baud); legal range 8..65535.
REQ-002 Parameter TIMEOUT_CYC, default 50_000_000, clk cycles without an accepted command before forced stop; legal range 2..2^32-1.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 rx  input  1  asynchronous UART line from the remote link; idle high; 8N1 format, LSB first.
REQ-006 dir_l  output  2  left motor direction code: 2'b10 forward, 2'b01 backward, 2'b00 stop; registered.
REQ-007 dir_r  output  2  right motor direction code, same encoding as dir_l; registered.
REQ-008 cmd_valid  output  1  one-cycle pulse when a command is accepted and applied.
REQ-009 cmd_err  output  1  one-cycle pulse when a well-framed byte carries an illegal command.
REQ-010 frame_err  output  1  one-cycle pulse when the stop bit samples low.
REQ-011 timeout  output  1  level; high while the watchdog stop is in force.

Function
REQ-012 rx SHALL pass through a 2-flop synchronizer; all FSM decisions SHALL use the synchronized value.
REQ-013 The receiver FSM SHALL have states IDLE, START, DATA, STOP and a bit-period counter of at least 16 bits.
REQ-014 IDLE -> START on a synchronized low; the counter clears.
REQ-015 START: at count CLKS_PER_BIT/2 (integer division), line high -> IDLE (false start, no pulse); line low -> DATA, counter clears.
REQ-016 DATA: every CLKS_PER_BIT cycles, sample one bit into the shift register, LSB first; after the 8th bit -> STOP.
REQ-017 STOP: after CLKS_PER_BIT cycles, sample the line, then return to IDLE in the same cycle.
REQ-018 If the stop sample is 0, the FSM SHALL pulse frame_err for one cycle, discard the byte, and leave the outputs unchanged.
REQ-019 Byte format: bits [7:4] SHALL equal 4'hA; bits [3:0] are the command {FWD,BWD,LEFT,RIGHT}.
REQ-020 Command map, {dir_l,dir_r}: 0000 -> 00,00; 1000 -> 10,10; 0100 -> 01,01; 0001 -> 10,01; 0010 -> 01,10; 1001 -> 10,00; 1010 -> 00,10; 0101 -> 01,00; 0110 -> 00,01.
REQ-021 Any other nibble, or bits [7:4] != 4'hA, SHALL pulse cmd_err for one cycle and leave dir_l, dir_r and the watchdog unchanged.
REQ-022 Latency: dir_l, dir_r and cmd_valid SHALL update on the clock edge immediately after the stop-bit sample cycle.
REQ-023 An accepted command SHALL clear the watchdog counter to 0 and deassert timeout on that same edge.
REQ-024 The watchdog SHALL count up each cycle while timeout is low; it SHALL NOT wrap.
REQ-025 When the watchdog counter reaches TIMEOUT_CYC-1, on the next edge timeout SHALL go 1 and dir_l and dir_r SHALL go 2'b00.
REQ-026 While timeout is high, the counter SHALL hold.
REQ-027 If a command is accepted in the same cycle the timeout would fire, the command SHALL win: it is applied and timeout stays 0.
REQ-028 A new start bit during STOP processing SHALL be ignored until the FSM is back in IDLE.
REQ-029 cmd_valid, cmd_err and frame_err SHALL be mutually exclusive.

Reset
REQ-030 While rst=1 on a clock edge: FSM -> IDLE; counters, shift register and synchronizer flops (to 1) clear; dir_l=dir_r=2'b00; cmd_valid=cmd_err=frame_err=0; timeout=0.
REQ-031 A frame in progress when rst asserts SHALL be abandoned; after release, reception SHALL restart only on a fresh falling edge.

Verification (CLKS_PER_BIT=16, TIMEOUT_CYC=1000)
REQ-032 Send 0xA8 -> one cmd_valid pulse; dir_l=2'b10, dir_r=2'b10 one cycle after the stop sample.
REQ-033 Send 0xA9, then 0xA3 -> after 0xA9, dir_l=10 and dir_r=00; after 0xA3, cmd_err pulses once and outputs stay 10/00.
REQ-034 Send 0xA8 with a stop bit of 0 -> frame_err pulses once; outputs and watchdog unchanged.
REQ-035 Drive a 5-cycle low glitch on rx -> no pulse; FSM returns to IDLE.
REQ-036 Send 0xA4, then idle 1000 cycles -> timeout=1 and dir_l=dir_r=00; send 0xA1 -> timeout=0, dir_l=10, dir_r=01.
REQ-037 Assert rst mid-DATA of 0xA8 -> all outputs 0; after release, send 0xA2 -> dir_l=01, dir_r=10.

Source files
------------

// File: rtl/car_cmd_rx.sv
// UART 8N1 command receiver driving two motor direction codes, with a no-command watchdog stop.
// Latency: outputs update on the edge after the stop-bit sample; no backpressure (rx is free-running).
module car_cmd_rx #(
  parameter int unsigned CLKS_PER_BIT = 10417,
  parameter int unsigned TIMEOUT_CYC  = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [1:0] dir_l,
  output logic [1:0] dir_r,
  output logic       cmd_valid,
  output logic       cmd_err,
  output logic       frame_err,
  output logic       timeout
);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  localparam logic [15:0] HALF_BIT = 16'(CLKS_PER_BIT / 2);
  localparam logic [15:0] LAST_BIT = 16'(CLKS_PER_BIT - 1);
  localparam logic [31:0] WD_LAST  = 32'(TIMEOUT_CYC - 1);

  state_t      state_q;
  logic        rx_meta_q, rx_sync_q;
  logic [15:0] cnt_q;
  logic [2:0]  bit_idx_q;
  logic [7:0]  shift_q;
  logic [31:0] wd_q;
  logic [1:0]  dir_l_q, dir_r_q;
  logic        cmd_valid_q, cmd_err_q, frame_err_q, timeout_q;

  logic        legal_d;
  logic [1:0]  dec_l_d, dec_r_d;
  logic        stop_tick, accept;

  always_comb begin
    legal_d = (shift_q[7:4] == 4'hA);
    dec_l_d = 2'b00;
    dec_r_d = 2'b00;
    case (shift_q[3:0])
      4'b0000: ;
      4'b1000: begin dec_l_d = 2'b10; dec_r_d = 2'b10; end
      4'b0100: begin dec_l_d = 2'b01; dec_r_d = 2'b01; end
      4'b0001: begin dec_l_d = 2'b10; dec_r_d = 2'b01; end
      4'b0010: begin dec_l_d = 2'b01; dec_r_d = 2'b10; end
      4'b1001: begin dec_l_d = 2'b10; dec_r_d = 2'b00; end
      4'b1010: begin dec_l_d = 2'b00; dec_r_d = 2'b10; end
      4'b0101: begin dec_l_d = 2'b01; dec_r_d = 2'b00; end
      4'b0110: begin dec_l_d = 2'b00; dec_r_d = 2'b01; end
      default: legal_d = 1'b0;
    endcase
  end

  assign stop_tick = (state_q == STOP) && (cnt_q == LAST_BIT);
  assign accept    = stop_tick && rx_sync_q && legal_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rx_meta_q   <= 1'b1;
      rx_sync_q   <= 1'b1;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      wd_q        <= '0;
      dir_l_q     <= 2'b00;
      dir_r_q     <= 2'b00;
      cmd_valid_q <= 1'b0;
      cmd_err_q   <= 1'b0;
      frame_err_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      rx_meta_q   <= rx;
      rx_sync_q   <= rx_meta_q;
      cmd_valid_q <= 1'b0;
      cmd_err_q   <= 1'b0;
      frame_err_q <= 1'b0;
      case (state_q)
        IDLE: if (!rx_sync_q) begin
          state_q <= START;
          cnt_q   <= '0;
        end
        START: if (cnt_q == HALF_BIT) begin
          cnt_q     <= '0;
          bit_idx_q <= '0;
          state_q   <= rx_sync_q ? IDLE : DATA;
        end else begin
          cnt_q <= cnt_q + 16'd1;
        end
        DATA: if (cnt_q == LAST_BIT) begin
          cnt_q     <= '0;
          shift_q   <= {rx_sync_q, shift_q[7:1]};
          bit_idx_q <= bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_q <= STOP;
        end else begin
          cnt_q <= cnt_q + 16'd1;
        end
        STOP: if (cnt_q == LAST_BIT) begin
          cnt_q   <= '0;
          state_q <= IDLE;
          if (!rx_sync_q)   frame_err_q <= 1'b1;
          else if (legal_d) cmd_valid_q <= 1'b1;
          else              cmd_err_q   <= 1'b1;
        end else begin
          cnt_q <= cnt_q + 16'd1;
        end
      endcase
      // An accepted command outranks a watchdog expiry on the same edge.
      if (accept) begin
        dir_l_q   <= dec_l_d;
        dir_r_q   <= dec_r_d;
        wd_q      <= '0;
        timeout_q <= 1'b0;
      end else if (!timeout_q) begin
        if (wd_q == WD_LAST) begin
          timeout_q <= 1'b1;
          dir_l_q   <= 2'b00;
          dir_r_q   <= 2'b00;
        end else begin
          wd_q <= wd_q + 32'd1;
        end
      end
    end
  end

  assign dir_l     = dir_l_q;
  assign dir_r     = dir_r_q;
  assign cmd_valid = cmd_valid_q;
  assign cmd_err   = cmd_err_q;
  assign frame_err = frame_err_q;
  assign timeout   = timeout_q;
endmodule
